// File: rtl/fsb_axis_sched_pkg.sv
// Shared types, state encoding and defaults for the FSB->AXIS transmit scheduler.
package fsb_axis_sched_pkg;

   localparam int unsigned FSB_PKT_W         = 80;
   localparam int unsigned DEF_AXIS_WIDTH    = 128;
   localparam int unsigned DEF_BURST_BEATS   = 4;
   localparam int unsigned DEF_FLUSH_TIMEOUT = 64;
   localparam int unsigned DEF_KEEP_W        = DEF_AXIS_WIDTH / 8;

   typedef logic [FSB_PKT_W-1:0] fsb_pkt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PAD  = 2'd2
   } sched_state_e;

   localparam logic [DEF_KEEP_W-1:0] TKEEP_DATA = '1;
   localparam logic [DEF_KEEP_W-1:0] TKEEP_PAD  = '0;

   // Counter width that stays legal for a modulus of 1.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsb_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the first valid requester at or after
// the pointer; the pointer moves past the grantee whenever a grant is issued.
module fsb_rr_arbiter
   import fsb_axis_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDW     = cnt_w(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IDW-1:0]     grant_id_c,
   output logic               grant_v_c
);

   logic [IDW-1:0] ptr;

   // Rotating priority search starting at the pointer.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      grant_v_c  = 1'b0;
      grant_id_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr) + 32'(i)) % NUM_REQ;
         if (en && !grant_v_c && req[IDW'(idx)]) begin
            grant_v_c  = 1'b1;
            grant_id_c = IDW'(idx);
         end
      end
      grant_c = grant_v_c ? (NUM_REQ'(1) << grant_id_c) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_v_c) begin
         ptr <= (grant_id_c == IDW'(NUM_REQ - 1)) ? '0 : grant_id_c + 1'b1;
      end
   end

endmodule

// File: rtl/fsb_axis_tx_scheduler.sv
// Shares one FSB->host AXIS path among NUM_REQ sources, framing beats into tlast bursts
// and padding stale partial bursts. FSB_SCHED_PERF_CNT_EN adds grant/pad perf counters.
module fsb_axis_tx_scheduler
   import fsb_axis_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ       = 4,
   parameter  int unsigned FSB_WIDTH     = FSB_PKT_W,
   parameter  int unsigned AXIS_WIDTH    = DEF_AXIS_WIDTH,
   parameter  int unsigned BURST_BEATS   = DEF_BURST_BEATS,
   parameter  int unsigned FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT,
   localparam int unsigned IDW           = cnt_w(NUM_REQ),
   localparam int unsigned KEEP_W        = AXIS_WIDTH / 8
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [NUM_REQ-1:0]                req_v_i,
   input  logic [NUM_REQ-1:0][FSB_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   output logic                              m_axis_tvalid_o,
   output logic [AXIS_WIDTH-1:0]             m_axis_tdata_o,
   output logic [KEEP_W-1:0]                 m_axis_tkeep_o,
   output logic                              m_axis_tlast_o,
   input  logic                              m_axis_tready_i,
   output logic [IDW-1:0]                    grant_id_o,
   output logic                              busy_o
`ifdef FSB_SCHED_PERF_CNT_EN
   ,
   output logic [NUM_REQ-1:0][31:0]          perf_grant_cnt_o,
   output logic [31:0]                       perf_pad_cnt_o
`endif
);

   localparam int unsigned BCW = cnt_w(BURST_BEATS);
   localparam int unsigned TOW = cnt_w(FLUSH_TIMEOUT);

   sched_state_e   state;
   logic [BCW-1:0] beat_cnt;
   logic [TOW-1:0] to_cnt;

   logic                 free_c;
   logic                 grant_en_c;
   logic [NUM_REQ-1:0]   grant_c;
   logic [IDW-1:0]       grant_id_c;
   logic                 grant_v_c;
   logic                 pad_load_c;
   logic                 last_c;
   logic                 idle_c;
   logic [FSB_WIDTH-1:0] pkt_c;

   assign free_c     = !m_axis_tvalid_o || m_axis_tready_i;
   assign grant_en_c = free_c && (state != PAD) && !reset_i;
   assign pad_load_c = free_c && (state == PAD);
   assign last_c     = (beat_cnt == BCW'(BURST_BEATS - 1));
   assign idle_c     = free_c && !(|req_v_i);
   assign pkt_c      = req_data_i[grant_id_c];
   assign busy_o     = (state != IDLE) || m_axis_tvalid_o;
   assign req_ready_o = grant_c;

   fsb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk        (clk_i),
      .reset      (reset_i),
      .en         (grant_en_c),
      .req        (req_v_i),
      .grant_c    (grant_c),
      .grant_id_c (grant_id_c),
      .grant_v_c  (grant_v_c)
   );

   // Output register, burst framing and flush FSM.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state           <= IDLE;
         beat_cnt        <= '0;
         to_cnt          <= '0;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tdata_o  <= '0;
         m_axis_tkeep_o  <= '0;
         m_axis_tlast_o  <= 1'b0;
         grant_id_o      <= '0;
      end else begin
         if (grant_v_c) begin
            m_axis_tvalid_o <= 1'b1;
            m_axis_tdata_o  <= AXIS_WIDTH'(pkt_c);
            m_axis_tkeep_o  <= '1;
            m_axis_tlast_o  <= last_c;
            grant_id_o      <= grant_id_c;
         end else if (pad_load_c) begin
            m_axis_tvalid_o <= 1'b1;
            m_axis_tdata_o  <= '0;
            m_axis_tkeep_o  <= '0;
            m_axis_tlast_o  <= last_c;
            grant_id_o      <= '0;
         end else if (free_c) begin
            m_axis_tvalid_o <= 1'b0;
         end

         if (grant_v_c || pad_load_c) begin
            beat_cnt <= last_c ? '0 : beat_cnt + 1'b1;
         end

         // Timeout only advances while the output could take a beat but nobody offers one.
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (grant_v_c && !last_c) state <= FILL;
            end
            FILL: begin
               if (grant_v_c) begin
                  to_cnt <= '0;
                  if (last_c) state <= IDLE;
               end else if (idle_c) begin
                  if (to_cnt == TOW'(FLUSH_TIMEOUT - 1)) begin
                     to_cnt <= '0;
                     state  <= PAD;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end
            PAD: begin
               if (pad_load_c && last_c) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FSB_SCHED_PERF_CNT_EN
   // Saturating per-requester accept counters and pad beat counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_grant_cnt_o <= '0;
         perf_pad_cnt_o   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i] && (perf_grant_cnt_o[i] != 32'hFFFF_FFFF)) begin
               perf_grant_cnt_o[i] <= perf_grant_cnt_o[i] + 32'd1;
            end
         end
         if (pad_load_c && (perf_pad_cnt_o != 32'hFFFF_FFFF)) begin
            perf_pad_cnt_o <= perf_pad_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fsb_axis_tx_scheduler.sv
// Directed bench for fsb_axis_tx_scheduler; perf counter checks build with FSB_SCHED_PERF_CNT_EN.
module tb_fsb_axis_tx_scheduler;
   import fsb_axis_sched_pkg::*;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
      logic [1:0]   gid;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      req_v;
   logic [3:0][79:0] req_data;
   logic [3:0]      req_ready;
   logic            tvalid;
   logic [127:0]    tdata;
   logic [15:0]     tkeep;
   logic            tlast;
   logic            tready;
   logic [1:0]      grant_id;
   logic            busy;
`ifdef FSB_SCHED_PERF_CNT_EN
   logic [3:0][31:0] perf_grant_cnt;
   logic [31:0]      perf_pad_cnt;
`endif

   int passed = 0;
   int total  = 0;
   beat_t mon_q[$];

   always #5 clk = ~clk;

   fsb_axis_tx_scheduler dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .req_v_i         (req_v),
      .req_data_i      (req_data),
      .req_ready_o     (req_ready),
      .m_axis_tvalid_o (tvalid),
      .m_axis_tdata_o  (tdata),
      .m_axis_tkeep_o  (tkeep),
      .m_axis_tlast_o  (tlast),
      .m_axis_tready_i (tready),
      .grant_id_o      (grant_id),
      .busy_o          (busy)
`ifdef FSB_SCHED_PERF_CNT_EN
      ,
      .perf_grant_cnt_o(perf_grant_cnt),
      .perf_pad_cnt_o  (perf_pad_cnt)
`endif
   );

   // Records every beat that completes a handshake on the following edge.
   always @(negedge clk) begin
      beat_t b;
      if (!reset && tvalid && tready) begin
         b.data = tdata;
         b.keep = tkeep;
         b.last = tlast;
         b.gid  = grant_id;
         mon_q.push_back(b);
      end
   end

   function automatic logic [79:0] pkt(input int i);
      return {8'hA5, 64'h0123_4567_89AB_CDEF, 8'(i)};
   endfunction

   function automatic beat_t data_beat(input int i, input logic last);
      beat_t b;
      b.data = {48'h0, pkt(i)};
      b.keep = TKEEP_DATA;
      b.last = last;
      b.gid  = 2'(i);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req_v  = '0;
      tready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      mon_q.delete();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      req_v    = 4'hF;
      req_data = '0;
      tready   = 1'b1;
      tick();
      tick();
      total++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", tvalid); else passed++;
      total++; if (tdata !== '0) $display("FAIL reset_tdata got %h exp 0", tdata); else passed++;
      total++; if (tkeep !== '0 || tlast !== 1'b0) $display("FAIL reset_keep_last got %h/%b exp 0/0", tkeep, tlast); else passed++;
      total++; if (grant_id !== 2'd0 || busy !== 1'b0) $display("FAIL reset_gid_busy got %0d/%b exp 0/0", grant_id, busy); else passed++;
      total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else passed++;
      reset = 1'b0;
      req_v = '0;
      mon_q.delete();
   endtask

   task automatic test_single_flush();
      do_reset();
      req_data[0] = 80'h0000_1234;
      req_v       = 4'b0001;
      #1;
      total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else passed++;
      tick();
      req_v = '0;
      total++; if (tvalid !== 1'b1) $display("FAIL single_tvalid got %b exp 1", tvalid); else passed++;
      total++; if (tdata !== 128'h1234) $display("FAIL single_tdata got %h exp %h", tdata, 128'h1234); else passed++;
      total++; if (tkeep !== 16'hFFFF || tlast !== 1'b0) $display("FAIL single_keep_last got %h/%b exp ffff/0", tkeep, tlast); else passed++;
      total++; if (grant_id !== 2'd0 || busy !== 1'b1) $display("FAIL single_gid_busy got %0d/%b exp 0/1", grant_id, busy); else passed++;
      repeat (63) tick();
      total++; if (tvalid !== 1'b0 || busy !== 1'b1) $display("FAIL flush_early got tvalid %b busy %b exp 0/1", tvalid, busy); else passed++;
      tick();
      total++; if (tvalid !== 1'b0) $display("FAIL flush_pad_timing got tvalid %b exp 0", tvalid); else passed++;
      tick();
      total++; if (tvalid !== 1'b1 || tkeep !== TKEEP_PAD || tdata !== '0 || tlast !== 1'b0)
         $display("FAIL pad1 got v%b k%h d%h l%b exp v1 k0000 d0 l0", tvalid, tkeep, tdata, tlast); else passed++;
      tick();
      tick();
      total++; if (tvalid !== 1'b1 || tkeep !== TKEEP_PAD || tlast !== 1'b1)
         $display("FAIL pad3 got v%b k%h l%b exp v1 k0000 l1", tvalid, tkeep, tlast); else passed++;
      tick();
      total++; if (tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_done got tvalid %b busy %b exp 0/0", tvalid, busy); else passed++;
      total++; if (mon_q.size() !== 4) $display("FAIL flush_beat_count got %0d exp 4", mon_q.size()); else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ready;
      do_reset();
      for (int i = 0; i < 4; i++) req_data[i] = pkt(i);
      req_v = 4'hF;
      for (int k = 0; k < 12; k++) begin
         #1;
         exp_ready = 4'b0001 << (k % 4);
         total++; if (req_ready !== exp_ready) $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_ready); else passed++;
         tick();
      end
      req_v = '0;
      tick();
      tick();
      total++; if (mon_q.size() !== 12) $display("FAIL rr_beat_count got %0d exp 12", mon_q.size()); else passed++;
      for (int k = 0; k < 12 && k < mon_q.size(); k++) begin
         total++; if (mon_q[k] !== data_beat(k % 4, (k % 4) == 3))
            $display("FAIL rr_beat[%0d] got %h exp %h", k, mon_q[k], data_beat(k % 4, (k % 4) == 3)); else passed++;
      end
      total++; if (busy !== 1'b0) $display("FAIL rr_idle_busy got %b exp 0", busy); else passed++;
   endtask

   task automatic test_backpressure();
      int held_bad;
      do_reset();
      for (int i = 0; i < 4; i++) req_data[i] = pkt(i);
      req_v = 4'hF;
      tick();
      tick();
      tready = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready got %b exp 0000", req_ready); else passed++;
      held_bad = 0;
      for (int c = 0; c < 80; c++) begin
         if (c == 10) req_v = '0;
         tick();
         if (tvalid !== 1'b1 || tdata !== {48'h0, pkt(1)} || tlast !== 1'b0 || grant_id !== 2'd1 || req_ready !== 4'b0000)
            held_bad++;
      end
      total++; if (held_bad !== 0) $display("FAIL bp_hold unstable cycles %0d exp 0", held_bad); else passed++;
      total++; if (mon_q.size() !== 1) $display("FAIL bp_stall_beats got %0d exp 1", mon_q.size()); else passed++;
      tready = 1'b1;
      req_v  = 4'hF;
      repeat (6) tick();
      req_v = '0;
      tick();
      tick();
      total++; if (mon_q.size() !== 8) $display("FAIL bp_beat_count got %0d exp 8", mon_q.size()); else passed++;
      for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
         total++; if (mon_q[k] !== data_beat(k % 4, (k % 4) == 3))
            $display("FAIL bp_beat[%0d] got %h exp %h", k, mon_q[k], data_beat(k % 4, (k % 4) == 3)); else passed++;
      end
   endtask

   task automatic test_timeout_race();
      do_reset();
      req_data[0] = pkt(0);
      req_v       = 4'b0001;
      tick();
      req_v = '0;
      repeat (63) tick();
      req_data[1] = pkt(1);
      req_v       = 4'b0010;
      #1;
      total++; if (req_ready !== 4'b0010) $display("FAIL race_ready got %b exp 0010", req_ready); else passed++;
      tick();
      req_v = '0;
      total++; if ({tvalid, tdata, tkeep, tlast, grant_id} !== {1'b1, 48'h0, pkt(1), 16'hFFFF, 1'b0, 2'd1})
         $display("FAIL race_beat got v%b d%h k%h l%b g%0d exp v1 d%h kffff l0 g1", tvalid, tdata, tkeep, tlast, grant_id, {48'h0, pkt(1)});
      else passed++;
      repeat (10) tick();
      total++; if (tvalid !== 1'b0 || busy !== 1'b1) $display("FAIL race_no_pad got tvalid %b busy %b exp 0/1", tvalid, busy); else passed++;
      total++; if (mon_q.size() !== 2) $display("FAIL race_beat_count got %0d exp 2", mon_q.size()); else passed++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_data[0] = pkt(0);
      req_data[1] = pkt(1);
      req_v       = 4'b0011;
      tick();
      tick();
      req_v = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if ({tvalid, tdata, tkeep, tlast, grant_id, busy, req_ready} !== '0)
         $display("FAIL midrst_outputs got v%b d%h k%h l%b g%0d b%b r%b exp all 0", tvalid, tdata, tkeep, tlast, grant_id, busy, req_ready);
      else passed++;
      mon_q.delete();
      req_data[2] = pkt(2);
      req_v       = 4'b0100;
      repeat (4) tick();
      req_v = '0;
      tick();
      tick();
      total++; if (mon_q.size() !== 4) $display("FAIL midrst_beat_count got %0d exp 4", mon_q.size()); else passed++;
      for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
         total++; if (mon_q[k] !== data_beat(2, k == 3))
            $display("FAIL midrst_beat[%0d] got %h exp %h", k, mon_q[k], data_beat(2, k == 3)); else passed++;
      end
   endtask

`ifdef FSB_SCHED_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      for (int i = 0; i < 4; i++) req_data[i] = pkt(i);
      req_v = 4'hF;
      repeat (12) tick();
      req_v = '0;
      tick();
      total++; if (perf_grant_cnt !== {32'd3, 32'd3, 32'd3, 32'd3})
         $display("FAIL perf_grant got %h exp 3 each", perf_grant_cnt); else passed++;
      total++; if (perf_pad_cnt !== 32'd0) $display("FAIL perf_pad_none got %0d exp 0", perf_pad_cnt); else passed++;
      req_v = 4'b0001;
      tick();
      req_v = '0;
      repeat (72) tick();
      total++; if (perf_pad_cnt !== 32'd3) $display("FAIL perf_pad got %0d exp 3", perf_pad_cnt); else passed++;
      total++; if (perf_grant_cnt[0] !== 32'd4) $display("FAIL perf_grant0 got %0d exp 4", perf_grant_cnt[0]); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_flush();
      test_round_robin();
      test_backpressure();
      test_timeout_race();
      test_reset_mid_burst();
`ifdef FSB_SCHED_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
